// File: rtl/pq_cmd_if.sv
// pq_cmd_if: request/response stream and register_tree side-band for pq_cmd_sequencer
interface pq_cmd_if #(
  parameter int QUEUE_SIZE = 31,
  parameter int DATA_WIDTH = 16
);
  localparam int CW = $clog2(QUEUE_SIZE + 1);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [1:0]            i_req_op;
  logic [DATA_WIDTH-1:0] i_req_data;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_rsp_err;
  logic                  o_pq_wrt;
  logic                  o_pq_read;
  logic [DATA_WIDTH-1:0] o_pq_data;
  logic                  i_pq_full;
  logic                  i_pq_empty;
  logic [DATA_WIDTH-1:0] i_pq_data;
  logic [CW-1:0]         o_count;
  modport slave (
    input  i_req_valid, i_req_op, i_req_data, i_rsp_ready, i_pq_full, i_pq_empty, i_pq_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_pq_wrt, o_pq_read, o_pq_data, o_count
  );
  modport master (
    output i_req_valid, i_req_op, i_req_data, i_rsp_ready, i_pq_full, i_pq_empty, i_pq_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_pq_wrt, o_pq_read, o_pq_data, o_count
  );
endinterface

// File: rtl/pq_cmd_sequencer.sv
// pq_cmd_sequencer: validates ENQ/DEQ/REPLACE requests and issues paced single-cycle register_tree pulses
module pq_cmd_sequencer #(
  parameter int QUEUE_SIZE = 31,
  parameter int DATA_WIDTH = 16,
  parameter int ENQ_GAP    = $clog2(QUEUE_SIZE) + 3,
  parameter int RD_GAP     = 3
) (
  input logic     clk,
  input logic     rst_n,
  pq_cmd_if.slave bus
);
  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam int GW = $clog2(ENQ_GAP + RD_GAP + 1);
  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  wrt_q, wrt_d;
  logic                  read_q, read_d;
  logic [DATA_WIDTH-1:0] pq_data_q, pq_data_d;
  logic                  accept, reject;
  assign bus.o_req_ready = (state_q == IDLE) && !rsp_valid_q;
  assign accept = bus.o_req_ready && bus.i_req_valid;
  // full/empty only trusted here: the tree is settled whenever we sit in IDLE
  assign reject = (bus.i_req_op == 2'b00) || (bus.i_req_op == OP_ENQ && bus.i_pq_full) ||
                  (bus.i_req_op[1] && bus.i_pq_empty);
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    gap_d       = gap_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q && !bus.i_rsp_ready;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    wrt_d       = 1'b0;
    read_d      = 1'b0;
    pq_data_d   = '0;
    if (accept) begin
      op_d        = bus.i_req_op;
      state_d     = reject ? IDLE : ISSUE;
      rsp_valid_d = reject;
      rsp_err_d   = reject;
      rsp_data_d  = '0;
      wrt_d       = !reject && bus.i_req_op[0];
      read_d      = !reject && bus.i_req_op[1];
      pq_data_d   = (!reject && bus.i_req_op[0]) ? bus.i_req_data : '0;
    end
    if (state_q == ISSUE) begin
      state_d     = WAIT;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      rsp_data_d  = op_q[1] ? bus.i_pq_data : '0;
      gap_d       = (op_q == OP_ENQ) ? GW'(ENQ_GAP) : GW'(RD_GAP);
      count_d     = (op_q == OP_ENQ && count_q != CW'(QUEUE_SIZE)) ? count_q + 1'b1 :
                    (op_q == OP_DEQ && count_q != '0) ? count_q - 1'b1 : count_q;
    end
    if (state_q == WAIT) begin
      gap_d   = (gap_q == '0) ? '0 : gap_q - 1'b1;
      state_d = (gap_q <= GW'(1)) ? IDLE : WAIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      gap_q       <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      wrt_q       <= 1'b0;
      read_q      <= 1'b0;
      pq_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      wrt_q       <= wrt_d;
      read_q      <= read_d;
      pq_data_q   <= pq_data_d;
    end
  end
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_pq_wrt    = wrt_q;
  assign bus.o_pq_read   = read_q;
  assign bus.o_pq_data   = pq_data_q;
  assign bus.o_count     = count_q;
endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// tb_pq_cmd_sequencer: scoreboard bench with a behavioural max-first register_tree fixture
module tb_pq_cmd_sequencer;
  localparam int QS      = 31;
  localparam int DW      = 16;
  localparam int ENQ_GAP = $clog2(QS) + 3;
  localparam int RD_GAP  = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW:0] exp_q[$];
  int refq[$];
  int tq[$];
  int pulse_cyc[$];
  logic pend_w = 1'b0;
  logic pend_r = 1'b0;
  logic [DW-1:0] pend_d = '0;
  logic last_w = 1'b0;
  logic last_r = 1'b0;
  logic [DW-1:0] last_d = '0;
  int last_cyc = 0;
  int min_sep = 0;
  bit have_last = 1'b0;
  pq_cmd_if #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) bus();
  pq_cmd_sequencer #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // tree fixture: applies the pulse seen at the previous negedge just after the edge that ends ISSUE
  always @(posedge clk) begin
    #1;
    if (!rst_n) tq.delete();
    else begin
      if (pend_r && tq.size() > 0) void'(tq.pop_front());
      if (pend_w) begin
        tq.push_back(int'(pend_d));
        tq.rsort();
      end
    end
    bus.i_pq_full  = (tq.size() == QS);
    bus.i_pq_empty = (tq.size() == 0);
    bus.i_pq_data  = (tq.size() > 0) ? DW'(tq[0]) : '0;
  end
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n && bus.o_rsp_valid && bus.i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got err=%0b data=%0h expected no response", bus.o_rsp_err, bus.o_rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", {15'd0, bus.o_rsp_err, bus.o_rsp_data}, {15'd0, e});
      end
    end
    pend_w = bus.o_pq_wrt;
    pend_r = bus.o_pq_read;
    pend_d = bus.o_pq_data;
    if (bus.o_pq_wrt || bus.o_pq_read) begin
      if (have_last) chk("pulse_gap", 32'((cyc - last_cyc) >= min_sep), 32'd1);
      min_sep = (bus.o_pq_wrt && !bus.o_pq_read) ? ENQ_GAP + 2 : RD_GAP + 2;
      last_cyc = cyc;
      have_last = 1'b1;
      last_w = bus.o_pq_wrt;
      last_r = bus.o_pq_read;
      last_d = bus.o_pq_data;
      pulse_cyc.push_back(cyc);
    end
  end
  task automatic ref_step(input logic [1:0] op, input logic [DW-1:0] d, output logic err, output logic [DW-1:0] data);
    if (op == 2'b00 || (op == 2'b01 && refq.size() == QS) || (op[1] && refq.size() == 0)) begin
      err = 1'b1;
      data = '0;
    end else begin
      err = 1'b0;
      data = op[1] ? DW'(refq[0]) : '0;
      if (op[1]) void'(refq.pop_front());
      if (op[0]) begin
        refq.push_back(int'(d));
        refq.rsort();
      end
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [DW-1:0] d, input bit use_ref,
                      input logic e_err, input logic [DW-1:0] e_data);
    logic r_err;
    logic [DW-1:0] r_data;
    int n = 0;
    ref_step(op, d, r_err, r_data);
    exp_q.push_back(use_ref ? {r_err, r_data} : {e_err, e_data});
    bus.i_req_valid = 1'b1;
    bus.i_req_op = op;
    bus.i_req_data = d;
    while (!bus.o_req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(n < 300), 32'd1);
    if (n < 300) begin
      @(posedge clk);
      #1;
    end
    bus.i_req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.o_req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(n < 300), 32'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0;
    logic [1:0] op;
    logic [DW-1:0] d;
    bus.i_req_valid = 1'b0;
    bus.i_req_op = 2'b00;
    bus.i_req_data = '0;
    bus.i_rsp_ready = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wrt", 32'(bus.o_pq_wrt), 32'd0);
    chk("rst_read", 32'(bus.o_pq_read), 32'd0);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
    // reset landing in the middle of an ISSUE cycle
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b1;
    bus.i_req_op = 2'b01;
    bus.i_req_data = 16'd55;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    chk("issue_wrt", 32'(bus.o_pq_wrt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wrt", 32'(bus.o_pq_wrt), 32'd0);
    chk("midrst_read", 32'(bus.o_pq_read), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("midrst_count", 32'(bus.o_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("midrst_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    // three ENQs back to back, then drain them max-first
    p0 = pulse_cyc.size();
    send(2'b01, 16'd100, 1'b0, 1'b0, 16'd0);
    send(2'b01, 16'd7, 1'b0, 1'b0, 16'd0);
    send(2'b01, 16'd513, 1'b0, 1'b0, 16'd0);
    drain();
    chk("enq_count", 32'(bus.o_count), 32'd3);
    chk("enq_pulses", 32'(pulse_cyc.size() - p0), 32'd3);
    chk("enq_spacing1", 32'(pulse_cyc[p0+1] - pulse_cyc[p0]), 32'd10);
    chk("enq_spacing2", 32'(pulse_cyc[p0+2] - pulse_cyc[p0+1]), 32'd10);
    send(2'b10, 16'd0, 1'b0, 1'b0, 16'd513);
    send(2'b10, 16'd0, 1'b0, 1'b0, 16'd100);
    send(2'b10, 16'd0, 1'b0, 1'b0, 16'd7);
    drain();
    chk("deq_count", 32'(bus.o_count), 32'd0);
    // DEQ on an empty tree is rejected without a pulse
    p0 = pulse_cyc.size();
    send(2'b10, 16'd0, 1'b0, 1'b1, 16'd0);
    drain();
    chk("deq_empty_nopulse", 32'(pulse_cyc.size() - p0), 32'd0);
    chk("deq_empty_count", 32'(bus.o_count), 32'd0);
    // fill to capacity with 1024 as the eventual root
    for (int i = 0; i < QS; i++) send(2'b01, (i == QS - 1) ? 16'd1024 : 16'(i + 1), 1'b0, 1'b0, 16'd0);
    drain();
    chk("fill_count", 32'(bus.o_count), 32'd31);
    p0 = pulse_cyc.size();
    send(2'b01, 16'd42, 1'b0, 1'b1, 16'd0);
    drain();
    chk("enq_full_nopulse", 32'(pulse_cyc.size() - p0), 32'd0);
    send(2'b11, 16'd5, 1'b0, 1'b0, 16'd1024);
    drain();
    chk("replace_pulses", 32'({last_w, last_r}), 32'd3);
    chk("replace_key", 32'(last_d), 32'd5);
    chk("replace_count", 32'(bus.o_count), 32'd31);
    chk("reserved_first", 32'(bus.o_count), 32'd31);
    send(2'b00, 16'd9, 1'b0, 1'b1, 16'd0);
    drain();
    // response back-pressure
    send(2'b10, 16'd0, 1'b0, 1'b0, 16'd30);
    drain();
    chk("bp_pre_count", 32'(bus.o_count), 32'd30);
    bus.i_rsp_ready = 1'b0;
    send(2'b01, 16'd77, 1'b0, 1'b0, 16'd0);
    repeat (15) @(negedge clk);
    chk("bp_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    chk("bp_req_ready", 32'(bus.o_req_ready), 32'd0);
    chk("bp_rsp_held", 32'({bus.o_rsp_err, bus.o_rsp_data}), 32'd0);
    chk("bp_count", 32'(bus.o_count), 32'd31);
    bus.i_rsp_ready = 1'b1;
    send(2'b10, 16'd0, 1'b0, 1'b0, 16'd77);
    drain();
    chk("bp_post_count", 32'(bus.o_count), 32'd30);
    // random mix against the reference model
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(0, 3));
      d = 16'($urandom_range(0, 4095));
      send(op, d, 1'b1, 1'b0, 16'd0);
    end
    drain();
    chk("rand_count", 32'(bus.o_count), 32'(refq.size()));
    chk("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
